// File: rtl/tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tile_renderer
// Description : Copies one 8x8 tile from the 64-tile sprite ROM (3-3-2 RGB)
//               into the 160x120 VGA framebuffer. Pixels are read row-major,
//               expanded to 24-bit colour and emitted as x/y/colour/plot.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        request pulse, honoured only when idle
//   tile_col     destination tile column (0..COLS-1)
//   tile_row     destination tile row    (0..ROWS-1)
//   tile_id      ROM tile index
//   rom_address  sprite ROM address {tile_id, py, px}
//   rom_data     sprite ROM data, valid one cycle after the address
//   x, y         pixel coordinate for the framebuffer
//   colour       24-bit expanded pixel colour
//   plot         framebuffer write strobe
//   busy         request in progress
//   done         one-cycle completion pulse
//   err          one-cycle pulse when a request is rejected
// ============================================================================
module tile_renderer #(
    parameter int         COLS           = 20,
    parameter int         ROWS           = 15,
    parameter int         TRANSPARENT_EN = 0,
    parameter logic [7:0] KEY_COLOUR     = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  tile_col,
    input  logic [4:0]  tile_row,
    input  logic [5:0]  tile_id,
    output logic [11:0] rom_address,
    input  logic [7:0]  rom_data,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [23:0] colour,
    output logic        plot,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [4:0] c_cols = 5'(COLS);
    localparam logic [4:0] c_rows = 5'(ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_pix;      // pixel currently presented on rom_address
    logic        r_flush;    // counts the two drain cycles
    logic [4:0]  r_col;
    logic [3:0]  r_row;      // rows are < 15, so four bits suffice
    logic [5:0]  r_id;

    // Second pipeline stage: travels alongside rom_data.
    logic        r_s2_valid;
    logic [2:0]  r_s2_px;
    logic [2:0]  r_s2_py;

    logic        w_reject;
    logic        w_transparent;
    logic [23:0] w_colour;

    assign w_reject      = (tile_col >= c_cols) || (tile_row >= c_rows);
    assign w_transparent = (TRANSPARENT_EN != 0) && (rom_data == KEY_COLOUR);

    // 3-3-2 to 8-8-8 by bit replication so full-scale maps to 8'hFF.
    assign w_colour = {rom_data[7:5], rom_data[7:5], rom_data[7:6],
                       rom_data[4:2], rom_data[4:2], rom_data[4:3],
                       rom_data[1:0], rom_data[1:0], rom_data[1:0], rom_data[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pix       <= 6'd0;
            r_flush     <= 1'b0;
            r_col       <= 5'd0;
            r_row       <= 4'd0;
            r_id        <= 6'd0;
            r_s2_valid  <= 1'b0;
            r_s2_px     <= 3'd0;
            r_s2_py     <= 3'd0;
            rom_address <= 12'd0;
            x           <= 8'd0;
            y           <= 7'd0;
            colour      <= 24'd0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Address stage -> data stage
            r_s2_valid <= (r_state == RUN);
            r_s2_px    <= r_pix[2:0];
            r_s2_py    <= r_pix[5:3];

            // Data stage -> output registers; coordinates are plain
            // concatenations because px/py never exceed 7.
            if (r_s2_valid) begin
                x      <= {r_col, r_s2_px};
                y      <= {r_row, r_s2_py};
                colour <= w_colour;
                plot   <= !w_transparent;
            end else begin
                plot   <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_reject) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            r_col       <= tile_col;
                            r_row       <= tile_row[3:0];
                            r_id        <= tile_id;
                            r_pix       <= 6'd0;
                            rom_address <= {tile_id, 6'd0};
                            busy        <= 1'b1;
                            r_state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (r_pix == 6'd63) begin
                        r_flush <= 1'b0;
                        r_state <= FLUSH;
                    end else begin
                        r_pix       <= r_pix + 6'd1;
                        rom_address <= {r_id, r_pix + 6'd1};
                    end
                end
                FLUSH: begin
                    // Two cycles let the last pixel leave the output stage.
                    if (r_flush) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_flush <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_renderer
// Description : Directed self-checking bench for tile_renderer. Two instances
//               share the stimulus: one opaque, one with transparency keyed
//               on 8'h00. Each has its own 1-cycle-latency ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  tile_col;
    logic [4:0]  tile_row;
    logic [5:0]  tile_id;

    logic [11:0] rom_address, rom_address_t;
    logic [7:0]  rom_data, rom_data_t;
    logic [7:0]  x, x_t;
    logic [6:0]  y, y_t;
    logic [23:0] colour, colour_t;
    logic        plot, plot_t, busy, busy_t, done, done_t, err, err_t;

    logic [7:0]  rom [0:4095];
    logic [23:0] hexc [0:3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tile_renderer dut (
        .clk(clk), .reset(reset), .start(start),
        .tile_col(tile_col), .tile_row(tile_row), .tile_id(tile_id),
        .rom_address(rom_address), .rom_data(rom_data),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .done(done), .err(err)
    );

    tile_renderer #(.TRANSPARENT_EN(1), .KEY_COLOUR(8'h00)) dut_t (
        .clk(clk), .reset(reset), .start(start),
        .tile_col(tile_col), .tile_row(tile_row), .tile_id(tile_id),
        .rom_address(rom_address_t), .rom_data(rom_data_t),
        .x(x_t), .y(y_t), .colour(colour_t), .plot(plot_t),
        .busy(busy_t), .done(done_t), .err(err_t)
    );

    always @(posedge clk) begin
        rom_data   <= rom[rom_address];
        rom_data_t <= rom[rom_address_t];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] expand(input logic [7:0] d);
        logic [7:0] r, g, b;
        r = {d[7:5], d[7:5], d[7:6]};
        g = {d[4:2], d[4:2], d[4:3]};
        b = {4{d[1:0]}};
        return {r, g, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a request and checks every cycle 1..67; returns in cycle 67
    // (the done cycle) so a following call tests back-to-back acceptance.
    task automatic draw(input logic [4:0] col, input logic [4:0] row,
                        input logic [5:0] id, input int poke_cyc, input int exp_t);
        int n0, n1, k;
        logic [11:0] a;
        logic [7:0]  d;
        tile_col = col; tile_row = row; tile_id = id; start = 1'b1;
        step();
        start = 1'b0;
        // Inputs change after acceptance; the latched values must be used.
        tile_col = 5'd7; tile_row = 5'd3; tile_id = 6'd63;
        n0 = 0; n1 = 0;
        for (int c = 1; c <= 67; c++) begin
            if (c == poke_cyc) begin
                start = 1'b1; tile_col = 5'd1; tile_row = 5'd1; tile_id = 6'd2;
            end else begin
                start = 1'b0;
            end
            chk("busy", busy, c <= 66);
            chk("done", done, c == 67);
            chk("err", err, 0);
            chk("done_t", done_t, c == 67);
            if (c <= 64) chk("addr", rom_address, {id, 6'(c - 1)});
            k = c - 3;
            if (c >= 3 && c <= 66) begin
                a = {id, 6'(k)};
                d = rom[a];
                chk("plot", plot, 1);
                chk("x", x, col * 8 + k % 8);
                chk("y", y, row * 8 + k / 8);
                chk("colour", colour, expand(d));
                chk("plot_t", plot_t, d != 8'h00);
                if (id == 6'd5 && k < 4) chk("hexcol", colour, hexc[k]);
            end else begin
                chk("plot", plot, 0);
                chk("plot_t", plot_t, 0);
            end
            n0 += int'(plot);
            n1 += int'(plot_t);
            if (c < 67) step();
        end
        chk("nplot", n0, 64);
        chk("nplot_t", n1, exp_t);
    endtask

    task automatic reject(input logic [4:0] col, input logic [4:0] row);
        tile_col = col; tile_row = row; tile_id = 6'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("rej_done", done, 1);
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_plot", plot, 0);
        step();
        chk("rej_done2", done, 0);
        chk("rej_err2", err, 0);
        chk("rej_busy2", busy, 0);
        chk("rej_plot2", plot, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, rom_address, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_colour"}, colour, 0);
        chk({tag, "_plot"}, plot, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'(i);
        rom[320] = 8'hE0; rom[321] = 8'h1C; rom[322] = 8'h03; rom[323] = 8'h92;
        for (int i = 0; i < 10; i++) rom[384 + i] = 8'h00;   // tile 6: 10 keyed pixels
        hexc[0] = 24'hFF0000; hexc[1] = 24'h00FF00;
        hexc[2] = 24'h0000FF; hexc[3] = 24'h9292AA;

        reset = 1'b1; start = 1'b0;
        tile_col = 5'd0; tile_row = 5'd0; tile_id = 6'd0;
        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        step();

        // Full tile 0: q = address, pixel 0 is the key colour for dut_t
        draw(5'd0, 5'd0, 6'd0, 0, 63);
        step();
        chk("idle_done", done, 0);

        // Bottom-right corner, colour expansion constants
        draw(5'd19, 5'd14, 6'd5, 0, 64);
        step();

        // Out-of-range requests, then a valid request (transparency tile)
        reject(5'd20, 5'd0);
        reject(5'd0, 5'd15);
        draw(5'd2, 5'd3, 6'd6, 0, 54);
        step();

        // Start while busy is ignored; next start coincides with done
        draw(5'd10, 5'd7, 6'd3, 30, 64);
        draw(5'd4, 5'd4, 6'd0, 0, 63);
        step();

        // Reset during pixel 30
        tile_col = 5'd1; tile_row = 5'd2; tile_id = 6'd4; start = 1'b1;
        step();
        start = 1'b0;
        repeat (32) step();                     // now in cycle 33
        chk("mid_plot", plot, 1);
        chk("mid_x", x, 8 + 30 % 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_zero("midrst");
        for (int i = 0; i < 75; i++) begin
            chk("post_rst_done", done, 0);
            chk("post_rst_plot", plot, 0);
            step();
        end
        draw(5'd5, 5'd5, 6'd1, 0, 64);
        step();

        // Reset and start together: request is lost
        tile_col = 5'd3; tile_row = 5'd3; tile_id = 6'd9;
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        chk("rs_busy", busy, 0);
        step();
        chk("rs_busy2", busy, 0);
        chk("rs_addr", rom_address, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
